pc_branch_unit: RTL and testbench
=================================

# pc_branch_unit

Program-counter and redirect stage of the CPU fetch path. It holds the PC, produces the sequential PC+4, and consumes the word-aligned branch offset from the shift-left-by-2 stage. It adds that offset to the branching instruction's PC+4 and redirects fetch on taken branches or jumps. A small FSM inserts a programmable fetch bubble after every redirect so the pipeline can squash wrong-path instructions.

## Interface
Parameters:
- DATA_SIZE, 32, PC/data width (≥ 32)
- RESET_PC, 0, PC value loaded on reset
- FLUSH_CYCLES, 1, bubble cycles after redirect (0..15; 0 = no bubble)

Ports:
- Clk  input  1  clock, all state updates on rising edge
- Rst_n  input  1  reset; asynchronous, active-low
- Stall  input  1  hold PC (hazard unit)
- BranchTaken  input  1  branch resolved taken this cycle
- BranchBase  input  DATA_SIZE  PC+4 of the branching instruction
- ShiftedOffset  input  DATA_SIZE  sign-extended immediate already shifted left by 2
- JumpEn  input  1  jump this cycle
- JumpIndex  input  26  jump instruction index field
- PC  output  DATA_SIZE  current fetch address (registered)
- PCPlus4  output  DATA_SIZE  PC + 4 (combinational from PC)
- FetchValid  output  1  fetch address valid this cycle
- Flush  output  1  redirect accepted this cycle; squash younger instructions
- MisalignErr  output  1  sticky target-misalignment flag (see Configuration)

## Operation
- Arithmetic: all adds are modulo 2^DATA_SIZE, carry discarded.
  - BranchTarget = BranchBase + ShiftedOffset.
  - JumpTarget = {PCPlus4[DATA_SIZE-1:28], JumpIndex, 2'b00}.
- Next-PC priority: JumpEn > BranchTaken > Stall > PCPlus4.
- FSM states:
  - BOOT: entered on reset. FetchValid=0, PC holds. Goes to RUN after one cycle.
  - RUN: FetchValid=1.
    - JumpEn or BranchTaken set: Flush=1 (combinational, same cycle), PC ← target at the edge, counter ← FLUSH_CYCLES. Goes to REDIRECT, or stays in RUN if FLUSH_CYCLES=0.
    - Else if Stall: PC holds.
    - Else: PC ← PCPlus4.
  - REDIRECT: FetchValid=0, Flush=0, PC holds. JumpEn, BranchTaken and Stall are ignored. Counter decrements each cycle; goes to RUN when counter reaches 1→0.
  - ERROR: exists only with the macro. FetchValid=0, PC frozen. Exit is by reset only.
- Flush is asserted only in RUN and is never asserted in BOOT or REDIRECT.
- Redirect overrides Stall in the same cycle.

## Timing
- Reset (async assert, Rst_n=0):
  - PC=RESET_PC, PCPlus4=RESET_PC+4.
  - FetchValid=0, Flush=0, MisalignErr=0.
  - state=BOOT, counter=0.
- Reset release: BOOT lasts 1 cycle. The first RUN cycle presents PC=RESET_PC with FetchValid=1.
- Sequential latency: PC advances one edge after a non-stalled RUN cycle.
- Redirect latency: target appears on PC one edge after the cycle with Flush=1. FetchValid is 0 for exactly FLUSH_CYCLES cycles, then 1 with PC=target.
- Wrap-around: PC=2^DATA_SIZE-4 advances to 0.
- Reset mid-REDIRECT or mid-ERROR: immediately returns to BOOT values; the counter is cleared.
- Stall held indefinitely in RUN: PC is constant and FetchValid stays 1.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - A redirect whose selected target has bits [1:0] ≠ 00 does not load PC and asserts no Flush.
  - The FSM enters ERROR on the next edge and MisalignErr sets (sticky until reset).
- PC_ALIGN_CHECK_EN undefined:
  - No check; the target is loaded as-is.
  - MisalignErr is tied 0 and the ERROR state is not built.

## Test plan
- Reset, then release with RESET_PC=0 → FetchValid 0 for 1 cycle; PC then steps 0x0, 0x4, 0x8 with FetchValid=1.
- At PC=0x10: BranchTaken=1, BranchBase=0x0C, ShiftedOffset=0x20 → Flush=1 that cycle; next PC=0x2C; FetchValid=0 for 1 cycle; fetch resumes at 0x2C, then 0x30.
- Same cycle JumpEn=1, JumpIndex=0x0000100, BranchTaken=1, Stall=1 → jump wins; PC=0x00000400; one Flush pulse.
- Stall=1 for 3 cycles at PC=0x40 → PC stays 0x40 and FetchValid=1; releasing Stall gives PC=0x44.
- PC=0xFFFFFFFC, no stall → next PC=0x00000000. Assert Rst_n=0 during REDIRECT with FLUSH_CYCLES=3 → PC=RESET_PC immediately; BOOT on release.
- With PC_ALIGN_CHECK_EN: BranchTaken, BranchBase=0x0E, ShiftedOffset=0x0 → PC unchanged, no Flush; MisalignErr=1 and FetchValid=0 until reset.

Source files
------------

// File: rtl/pc_branch_unit.sv
// Fetch-path program counter with branch/jump redirect and a post-redirect fetch bubble.
// Optional target alignment checking is enabled by defining PC_ALIGN_CHECK_EN.
module pc_branch_unit #(
  parameter int                   DATA_SIZE    = 32,
  parameter logic [DATA_SIZE-1:0] RESET_PC     = '0,
  parameter int                   FLUSH_CYCLES = 1
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Stall,
  input  logic                 BranchTaken,
  input  logic [DATA_SIZE-1:0] BranchBase,
  input  logic [DATA_SIZE-1:0] ShiftedOffset,
  input  logic                 JumpEn,
  input  logic [25:0]          JumpIndex,
  output logic [DATA_SIZE-1:0] PC,
  output logic [DATA_SIZE-1:0] PCPlus4,
  output logic                 FetchValid,
  output logic                 Flush,
  output logic                 MisalignErr
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

`ifdef PC_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_REDIRECT, S_ERROR} state_t;
`else
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_REDIRECT} state_t;
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DATA_SIZE-1:0] r_pc;
  logic [DATA_SIZE-1:0] w_pc_nxt;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;

  logic [DATA_SIZE-1:0] w_pc4;
  logic [DATA_SIZE-1:0] w_br_tgt;
  logic [DATA_SIZE-1:0] w_jmp_tgt;
  logic [DATA_SIZE-1:0] w_tgt;
  logic                 w_redir;
  logic                 w_fetch_vld;
  logic                 w_flush;

  assign w_pc4     = r_pc + DATA_SIZE'(4);
  assign w_br_tgt  = BranchBase + ShiftedOffset;
  assign w_jmp_tgt = {w_pc4[DATA_SIZE-1:28], JumpIndex, 2'b00};
  assign w_redir   = JumpEn | BranchTaken;
  assign w_tgt     = JumpEn ? w_jmp_tgt : w_br_tgt;

`ifdef PC_ALIGN_CHECK_EN
  logic r_misalign;
  logic w_misalign;
  logic w_mis_set;

  assign w_misalign = (w_tgt[1:0] != 2'b00);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_fetch_vld = 1'b0;
    w_flush     = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    w_mis_set   = 1'b0;
`endif
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_fetch_vld = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
        if (w_redir && w_misalign) begin
          w_state_nxt = S_ERROR;
          w_mis_set   = 1'b1;
        end else
`endif
        if (w_redir) begin
          // Redirect wins over Stall; with no bubble configured we stay in RUN.
          w_flush   = 1'b1;
          w_pc_nxt  = w_tgt;
          w_cnt_nxt = FLUSH_INIT;
          if (FLUSH_CYCLES != 0) w_state_nxt = S_REDIRECT;
        end else if (!Stall) begin
          w_pc_nxt = w_pc4;
        end
      end
      S_REDIRECT: begin
        if (r_cnt <= 4'd1) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
`ifdef PC_ALIGN_CHECK_EN
      S_ERROR: begin
        w_state_nxt = S_ERROR;
      end
`endif
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_misalign <= 1'b0;
    else if (w_mis_set) r_misalign <= 1'b1;
  end

  assign MisalignErr = r_misalign;
`else
  assign MisalignErr = 1'b0;
`endif

  assign PC         = r_pc;
  assign PCPlus4    = w_pc4;
  assign FetchValid = w_fetch_vld;
  assign Flush      = w_flush;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Table-driven bench for pc_branch_unit: a one-cycle-bubble instance runs the vector table,
// a three-cycle-bubble instance runs hand-written redirect and mid-redirect reset sequences.
module tb_pc_branch_unit;

  logic        Clk;
  logic        Rst_n, Rst3_n;
  logic        Stall, BranchTaken, JumpEn;
  logic [31:0] BranchBase, ShiftedOffset;
  logic [25:0] JumpIndex;

  logic [31:0] pc, pc4, pc3, pc43;
  logic        fv, fl, me, fv3, fl3, me3;

  int checks   = 0;
  int failures = 0;

  pc_branch_unit #(.DATA_SIZE(32), .RESET_PC(32'h0), .FLUSH_CYCLES(1)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchBase(BranchBase), .ShiftedOffset(ShiftedOffset), .JumpEn(JumpEn),
    .JumpIndex(JumpIndex), .PC(pc), .PCPlus4(pc4), .FetchValid(fv), .Flush(fl),
    .MisalignErr(me)
  );

  pc_branch_unit #(.DATA_SIZE(32), .RESET_PC(32'h0), .FLUSH_CYCLES(3)) u_dut3 (
    .Clk(Clk), .Rst_n(Rst3_n), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchBase(BranchBase), .ShiftedOffset(ShiftedOffset), .JumpEn(JumpEn),
    .JumpIndex(JumpIndex), .PC(pc3), .PCPlus4(pc43), .FetchValid(fv3), .Flush(fl3),
    .MisalignErr(me3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic        stall;
    logic        bt;
    logic [31:0] base;
    logic [31:0] off;
    logic        je;
    logic [25:0] jidx;
    logic [31:0] pc;
    logic        fv;
    logic        fl;
    logic        me;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        fv;
    logic        fl;
    logic        me;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic add(input string nm, input logic st, input logic bt, input logic [31:0] base,
                     input logic [31:0] off, input logic je, input logic [25:0] jidx,
                     input logic [31:0] epc, input logic efv, input logic efl, input logic eme);
    vec_t v;
    v.name = nm; v.stall = st; v.bt = bt; v.base = base; v.off = off; v.je = je;
    v.jidx = jidx; v.pc = epc; v.fv = efv; v.fl = efl; v.me = eme;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    Stall = 0; BranchTaken = 0; JumpEn = 0;
    BranchBase = '0; ShiftedOffset = '0; JumpIndex = '0;
  endtask

  initial begin
    vec_t v;
    exp_t e;
    idle_inputs();
    Rst_n  = 1'b1;
    Rst3_n = 1'b1;
    #2;
    Rst_n  = 1'b0;
    Rst3_n = 1'b0;
    #2;
    chk("reset_pc",    pc,  32'h0);
    chk("reset_pc4",   pc4, 32'h4);
    chk("reset_fv",    fv,  1'b0);
    chk("reset_flush", fl,  1'b0);
    chk("reset_mis",   me,  1'b0);
    chk("reset3_pc",   pc3, 32'h0);

    add("run0",        0, 0, 32'h0,        32'h0,  0, 26'h0,   32'h0,        1, 0, 0);
    add("run4",        0, 0, 32'h0,        32'h0,  0, 26'h0,   32'h4,        1, 0, 0);
    add("run8",        0, 0, 32'h0,        32'h0,  0, 26'h0,   32'h8,        1, 0, 0);
    add("runC",        0, 0, 32'h0,        32'h0,  0, 26'h0,   32'hC,        1, 0, 0);
    add("br_take",     0, 1, 32'hC,        32'h20, 0, 26'h0,   32'h10,       1, 1, 0);
    add("br_bubble",   1, 1, 32'h100,      32'h4,  0, 26'h0,   32'h2C,       0, 0, 0);
    add("br_target",   0, 0, 32'h0,        32'h0,  0, 26'h0,   32'h2C,       1, 0, 0);
    add("jmp_win",     1, 1, 32'h100,      32'h8,  1, 26'h100, 32'h30,       1, 1, 0);
    add("jmp_bubble",  1, 0, 32'h0,        32'h0,  1, 26'h3,   32'h400,      0, 0, 0);
    add("jmp_to40",    0, 0, 32'h0,        32'h0,  1, 26'h10,  32'h400,      1, 1, 0);
    add("b40_bubble",  0, 0, 32'h0,        32'h0,  0, 26'h0,   32'h40,       0, 0, 0);
    add("stall1",      1, 0, 32'h0,        32'h0,  0, 26'h0,   32'h40,       1, 0, 0);
    add("stall2",      1, 0, 32'h0,        32'h0,  0, 26'h0,   32'h40,       1, 0, 0);
    add("stall3",      1, 0, 32'h0,        32'h0,  0, 26'h0,   32'h40,       1, 0, 0);
    add("unstall",     0, 0, 32'h0,        32'h0,  0, 26'h0,   32'h40,       1, 0, 0);
    add("br_wrap",     0, 1, 32'hFFFFFFF0, 32'hC,  0, 26'h0,   32'h44,       1, 1, 0);
    add("wrap_bubble", 0, 0, 32'h0,        32'h0,  0, 26'h0,   32'hFFFFFFFC, 0, 0, 0);
    add("wrap_top",    0, 0, 32'h0,        32'h0,  0, 26'h0,   32'hFFFFFFFC, 1, 0, 0);
    add("wrap_zero",   0, 0, 32'h0,        32'h0,  0, 26'h0,   32'h0,        1, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    add("mis_br",      0, 1, 32'hE,        32'h0,  0, 26'h0,   32'h4,        1, 0, 0);
    add("mis_err1",    0, 0, 32'h0,        32'h0,  0, 26'h0,   32'h4,        0, 0, 1);
    add("mis_err2",    0, 1, 32'h10,       32'h0,  1, 26'h20,  32'h4,        0, 0, 1);
    add("mis_err3",    0, 0, 32'h0,        32'h0,  0, 26'h0,   32'h4,        0, 0, 1);
`else
    add("mis_br",      0, 1, 32'hE,        32'h0,  0, 26'h0,   32'h4,        1, 1, 0);
    add("mis_bubble",  0, 0, 32'h0,        32'h0,  0, 26'h0,   32'hE,        0, 0, 0);
    add("mis_load",    0, 0, 32'h0,        32'h0,  0, 26'h0,   32'hE,        1, 0, 0);
    add("mis_next",    0, 0, 32'h0,        32'h0,  0, 26'h0,   32'h12,       1, 0, 0);
`endif

    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    #2;
    chk("boot_fv", fv, 1'b0);
    chk("boot_pc", pc, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge Clk);
      Stall = v.stall; BranchTaken = v.bt; BranchBase = v.base; ShiftedOffset = v.off;
      JumpEn = v.je; JumpIndex = v.jidx;
      e.name = v.name; e.pc = v.pc; e.fv = v.fv; e.fl = v.fl; e.me = v.me;
      sb.push_back(e);
      #2;
      e = sb.pop_front();
      chk($sformatf("%s_pc", e.name),    pc,  e.pc);
      chk($sformatf("%s_pc4", e.name),   pc4, e.pc + 32'h4);
      chk($sformatf("%s_fv", e.name),    fv,  e.fv);
      chk($sformatf("%s_flush", e.name), fl,  e.fl);
      chk($sformatf("%s_mis", e.name),   me,  e.me);
    end
    chk("sb_drained", sb.size(), 0);

    // Three-cycle bubble instance: full redirect, then reset in the middle of a redirect.
    @(negedge Clk);
    idle_inputs();
    Rst3_n = 1'b1;
    #2;
    chk("f3_boot_fv", fv3, 1'b0);
    @(negedge Clk);
    JumpEn = 1; JumpIndex = 26'h40;
    #2;
    chk("f3_jmp_fv", fv3, 1'b1);
    chk("f3_jmp_flush", fl3, 1'b1);
    chk("f3_jmp_pc", pc3, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      JumpEn = (k == 0); BranchTaken = 1; Stall = 1; BranchBase = 32'h80;
      #2;
      chk($sformatf("f3_bubble%0d_fv", k), fv3, 1'b0);
      chk($sformatf("f3_bubble%0d_flush", k), fl3, 1'b0);
      chk($sformatf("f3_bubble%0d_pc", k), pc3, 32'h100);
    end
    @(negedge Clk);
    idle_inputs();
    #2;
    chk("f3_resume_fv", fv3, 1'b1);
    chk("f3_resume_pc", pc3, 32'h100);
    @(negedge Clk);
    JumpEn = 1; JumpIndex = 26'h80;
    #2;
    chk("f3_jmp2_flush", fl3, 1'b1);
    @(negedge Clk);
    idle_inputs();
    #2;
    chk("f3_mid_pc", pc3, 32'h200);
    chk("f3_mid_fv", fv3, 1'b0);
    #1;
    Rst3_n = 1'b0;
    #1;
    chk("f3_rst_pc",    pc3,  32'h0);
    chk("f3_rst_pc4",   pc43, 32'h4);
    chk("f3_rst_fv",    fv3,  1'b0);
    chk("f3_rst_flush", fl3,  1'b0);
    chk("f3_rst_mis",   me3,  1'b0);
    @(negedge Clk);
    Rst3_n = 1'b1;
    #2;
    chk("f3_reboot_fv", fv3, 1'b0);
    chk("f3_reboot_pc", pc3, 32'h0);
    @(negedge Clk);
    #2;
    chk("f3_rerun_fv", fv3, 1'b1);
    chk("f3_rerun_pc", pc3, 32'h0);
    @(negedge Clk);
    #2;
    chk("f3_rerun_pc4", pc3, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
